// File: rtl/axis_spi_frame_writer_pkg.sv
// Shared state encoding and width helper for the AXI-Stream to SPI frame writer.
package axis_spi_frame_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_GAP
  } state_e;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/axis_spi_frame_writer_spi_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module spi_phase_timer #(
  parameter int W = 2
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/axis_spi_frame_writer.sv
// Splits one AXI-Stream word into FRAMES SPI mode-0 frames, MSB frame first,
// with a chip-select pulse per frame. Words arriving while busy set a sticky overrun.
module axis_spi_frame_writer
  import axis_spi_frame_writer_pkg::*;
#(
  parameter int FRAME_WIDTH = 24,
  parameter int FRAMES      = 3,
  parameter int CLK_DIV     = 4,
  parameter int CS_GAP      = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [FRAME_WIDTH*FRAMES-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic                          spi_sclk,
  output logic                          spi_mosi,
  output logic                          spi_cs_n,
  output logic                          busy,
  output logic                          overrun
);

  localparam int DW = FRAME_WIDTH * FRAMES;
  localparam int TW = clog2_min1((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP);
  localparam int BW = clog2_min1(FRAME_WIDTH);
  localparam int FW = clog2_min1(FRAMES);
  localparam logic [TW-1:0] DIV_LD   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(CS_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_WIDTH - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(FRAMES - 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic            last_q, last_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            cs_n_q, cs_n_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic            tmr_load, tmr_tc;
  logic [TW-1:0]   tmr_val;

  assign s_axis_tready = (state_q == ST_IDLE) & aresetn;

  spi_phase_timer #(.W(TW)) u_timer (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    last_d      = last_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    tmr_load    = 1'b0;
    tmr_val     = DIV_LD;
    if (s_axis_tvalid && state_q != ST_IDLE) overrun_d = 1'b1;
    case (state_q)
      ST_IDLE: if (s_axis_tvalid && s_axis_tready) begin
        state_d     = ST_SETUP;
        shreg_d     = s_axis_tdata;
        bit_cnt_d   = '0;
        frame_cnt_d = '0;
        last_d      = 1'b0;
        sclk_d      = 1'b0;
        cs_n_d      = 1'b0;
        mosi_d      = s_axis_tdata[DW-1];
        busy_d      = 1'b1;
        tmr_load    = 1'b1;
      end
      ST_SETUP: if (tmr_tc) begin
        state_d  = ST_SHIFT_HI;
        sclk_d   = 1'b1;
        tmr_load = 1'b1;
      end
      ST_SHIFT_HI: if (tmr_tc) begin
        state_d  = ST_SHIFT_LO;
        sclk_d   = 1'b0;
        tmr_load = 1'b1;
        // After the last bit the LSB stays on mosi; otherwise present the next bit.
        if (bit_cnt_q == BIT_LAST) begin
          last_d = 1'b1;
        end else begin
          shreg_d   = shreg_q << 1;
          mosi_d    = shreg_q[DW-2];
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      ST_SHIFT_LO: if (tmr_tc) begin
        tmr_load = 1'b1;
        if (last_q) begin
          state_d = ST_GAP;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          tmr_val = GAP_LD;
        end else begin
          state_d = ST_SHIFT_HI;
          sclk_d  = 1'b1;
        end
      end
      ST_GAP: if (tmr_tc) begin
        if (frame_cnt_q != FRM_LAST) begin
          // One more shift brings the next frame's MSB to the top.
          state_d     = ST_SETUP;
          frame_cnt_d = frame_cnt_q + FW'(1);
          shreg_d     = shreg_q << 1;
          mosi_d      = shreg_q[DW-2];
          cs_n_d      = 1'b0;
          bit_cnt_d   = '0;
          last_d      = 1'b0;
          tmr_load    = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      last_q      <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      last_q      <= last_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_axis_spi_frame_writer.sv
// Directed bench: default instance plus a CLK_DIV=1/CS_GAP=1/FRAMES=2 instance, each with an SPI slave monitor.
module tb_axis_spi_frame_writer;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [71:0] td0 = '0;
  logic        tv0 = 1'b0, tr0, sclk0, mosi0, cs0, busy0, ovr0;
  logic [47:0] td1 = '0;
  logic        tv1 = 1'b0, tr1, sclk1, mosi1, cs1, busy1, ovr1;

  axis_spi_frame_writer dut0 (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(td0), .s_axis_tvalid(tv0),
    .s_axis_tready(tr0), .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_cs_n(cs0),
    .busy(busy0), .overrun(ovr0));

  axis_spi_frame_writer #(.FRAME_WIDTH(24), .FRAMES(2), .CLK_DIV(1), .CS_GAP(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(td1), .s_axis_tvalid(tv1),
    .s_axis_tready(tr1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_cs_n(cs1),
    .busy(busy1), .overrun(ovr1));

  // SPI slave monitors: frame data, rising-edge count, cs_n low/high lengths in aclk cycles.
  logic ps0 = 1'b0, pc0 = 1'b1, ps1 = 1'b0, pc1 = 1'b1;
  int lc0 = 0, hc0 = 0, ec0 = 0, lc1 = 0, hc1 = 0, ec1 = 0;
  logic [23:0] sh0 = '0, sh1 = '0;
  logic [23:0] fq0[$], fq1[$];
  int eq0[$], lq0[$], gq0[$], eq1[$], lq1[$], gq1[$];

  always @(negedge aclk) begin
    if (!cs0) begin
      if (pc0) begin lc0 = 0; ec0 = 0; sh0 = '0; gq0.push_back(hc0); end
      lc0++;
      if (sclk0 && !ps0) begin sh0 = {sh0[22:0], mosi0}; ec0++; end
    end else begin
      if (!pc0) begin
        hc0 = 0;
        if (aresetn) begin fq0.push_back(sh0); eq0.push_back(ec0); lq0.push_back(lc0); end
      end
      hc0++;
    end
    ps0 = sclk0; pc0 = cs0;
  end

  always @(negedge aclk) begin
    if (!cs1) begin
      if (pc1) begin lc1 = 0; ec1 = 0; sh1 = '0; gq1.push_back(hc1); end
      lc1++;
      if (sclk1 && !ps1) begin sh1 = {sh1[22:0], mosi1}; ec1++; end
    end else begin
      if (!pc1) begin
        hc1 = 0;
        if (aresetn) begin fq1.push_back(sh1); eq1.push_back(ec1); lq1.push_back(lc1); end
      end
      hc1++;
    end
    ps1 = sclk1; pc1 = cs1;
  end

  int tests = 0, fails = 0;
  logic [23:0] ex[6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic clear_q();
    fq0.delete(); eq0.delete(); lq0.delete(); gq0.delete();
    fq1.delete(); eq1.delete(); lq1.delete(); gq1.delete();
  endtask

  // Counts negedge samples with tready low; leaves us at the first sample with tready high.
  task automatic wait_ready(input int which, output int n);
    n = 0;
    while (((which == 0) ? tr0 : tr1) == 1'b0 && n < 5000) begin
      n++;
      tick();
    end
  endtask

  task automatic send0(input logic [71:0] w);
    td0 = w; tv0 = 1'b1;
    tick();
    tv0 = 1'b0;
  endtask

  task automatic chk_frames0(input string tag, input int n);
    chk({tag, "_nframes"}, fq0.size(), n);
    for (int i = 0; i < n && i < fq0.size(); i++) begin
      chk($sformatf("%s_f%0d_data", tag, i), {8'h0, fq0[i]}, {8'h0, ex[i]});
      chk($sformatf("%s_f%0d_edges", tag, i), eq0[i], 24);
      chk($sformatf("%s_f%0d_cslow", tag, i), lq0[i], 196);
    end
  endtask

  int n;

  initial begin
    repeat (3) tick();
    chk("rst_sclk", sclk0, 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_cs_n", cs0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_overrun", ovr0, 0);
    chk("rst_tready", tr0, 0);
    chk("rst_tready_p", tr1, 0);
    aresetn = 1'b1;
    tick();
    chk("idle_tready", tr0, 1);
    chk("idle_tready_p", tr1, 1);
    clear_q();

    // Nominal word
    send0({24'h250000, 8'h14, 16'h1234, 8'h11, 16'hABCD});
    chk("nom_busy", busy0, 1);
    chk("nom_cs_low", cs0, 0);
    chk("nom_mosi_msb", mosi0, 0);
    chk("nom_tready_low", tr0, 0);
    wait_ready(0, n);
    chk("nom_tready_cycles", n, 600);
    chk("nom_busy_end", busy0, 0);
    ex[0] = 24'h250000; ex[1] = 24'h141234; ex[2] = 24'h11ABCD;
    chk_frames0("nom", 3);
    chk("nom_gap1", (gq0.size() > 1) ? gq0[1] : -1, 4);
    chk("nom_gap2", (gq0.size() > 2) ? gq0[2] : -1, 4);
    clear_q();

    // Back-to-back: second word presented in the cycle tready returns high
    send0(72'hFFFFFF_000000_AAAAAA);
    wait_ready(0, n);
    chk("b2b_tready_cycles1", n, 600);
    td0 = 72'h000001_800000_555555; tv0 = 1'b1;
    tick();
    tv0 = 1'b0;
    chk("b2b_accept_busy", busy0, 1);
    chk("b2b_accept_cs", cs0, 0);
    wait_ready(0, n);
    chk("b2b_tready_cycles2", n, 600);
    ex[0] = 24'hFFFFFF; ex[1] = 24'h000000; ex[2] = 24'hAAAAAA;
    ex[3] = 24'h000001; ex[4] = 24'h800000; ex[5] = 24'h555555;
    chk_frames0("b2b", 6);
    chk("b2b_overrun", ovr0, 0);
    clear_q();

    // Overrun: second pulse while busy is dropped
    send0(72'h123456_789ABC_DEF012);
    repeat (99) tick();
    chk("ovr_pre", ovr0, 0);
    td0 = 72'hBAD0BA_D0BAD0_BAD0BA; tv0 = 1'b1;
    tick();
    tv0 = 1'b0;
    chk("ovr_set", ovr0, 1);
    wait_ready(0, n);
    chk("ovr_tready_cycles", n, 500);
    repeat (50) tick();
    ex[0] = 24'h123456; ex[1] = 24'h789ABC; ex[2] = 24'hDEF012;
    chk_frames0("ovr", 3);
    chk("ovr_sticky", ovr0, 1);
    chk("ovr_idle_cs", cs0, 1);

    // Reset mid-frame (bit 10 of frame 1)
    aresetn = 1'b0;
    tick();
    chk("ovr_clear", ovr0, 0);
    aresetn = 1'b1;
    tick();
    clear_q();
    send0(72'hA5A5A5_5A5A5A_0F0F0F);
    repeat (286) tick();
    chk("mid_in_frame1", fq0.size(), 1);
    chk("mid_sclk_hi", sclk0, 1);
    aresetn = 1'b0;
    tick();
    chk("mid_rst_cs", cs0, 1);
    chk("mid_rst_sclk", sclk0, 0);
    chk("mid_rst_mosi", mosi0, 0);
    chk("mid_rst_tready", tr0, 0);
    chk("mid_rst_busy", busy0, 0);
    tick();
    chk("mid_partial_dropped", fq0.size(), 1);
    aresetn = 1'b1;
    tick();
    chk("mid_release_tready", tr0, 1);
    repeat (20) tick();
    chk("mid_not_resumed", cs0, 1);
    clear_q();
    send0(72'h3C3C3C_C3C3C3_010203);
    wait_ready(0, n);
    chk("mid_new_tready_cycles", n, 600);
    ex[0] = 24'h3C3C3C; ex[1] = 24'hC3C3C3; ex[2] = 24'h010203;
    chk_frames0("mid_new", 3);
    clear_q();

    // Parameter sweep instance
    td1 = 48'hC3A5F0_0F1E2D; tv1 = 1'b1;
    tick();
    tv1 = 1'b0;
    chk("sw_busy", busy1, 1);
    chk("sw_mosi_msb", mosi1, 1);
    wait_ready(1, n);
    chk("sw_tready_cycles", n, 100);
    chk("sw_nframes", fq1.size(), 2);
    if (fq1.size() == 2) begin
      chk("sw_f0_data", {8'h0, fq1[0]}, 32'hC3A5F0);
      chk("sw_f1_data", {8'h0, fq1[1]}, 32'h0F1E2D);
      chk("sw_f0_edges", eq1[0], 24);
      chk("sw_f1_edges", eq1[1], 24);
      chk("sw_f0_cslow", lq1[0], 49);
      chk("sw_f1_cslow", lq1[1], 49);
      chk("sw_gap", (gq1.size() > 1) ? gq1[1] : -1, 1);
    end
    chk("sw_overrun", ovr1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
